// File: rtl/interface_hcsr04_multi_pkg.sv
// Shared state codes, 50 MHz default timing constants and sizing helper
// for the multi-channel HC-SR04 interface.
package interface_hcsr04_multi_pkg;

    typedef enum logic [3:0] {
        INICIAL     = 4'd0,
        PREPARA     = 4'd1,
        TRIGGER     = 4'd2,
        ESPERA_ECHO = 4'd3,
        MEDINDO     = 4'd4,
        REGISTRA    = 4'd5,
        PAUSA       = 4'd6,
        FINAL       = 4'd7
    } estado_t;

    localparam int DEF_N_CANAIS       = 2;
    localparam int DEF_LARGURA        = 12;
    localparam int DEF_CICLOS_TRIGGER = 500;
    localparam int DEF_CICLOS_CM      = 2941;
    localparam int DEF_TIMEOUT_CM     = 400;
    localparam int DEF_CICLOS_PAUSA   = 3_000_000;

    // Bits needed for a counter that must hold the value maximo.
    function automatic int largura_contador(input int maximo);
        return (maximo < 2) ? 1 : $clog2(maximo + 1);
    endfunction

endpackage

// File: rtl/interface_hcsr04_multi_contador_cm.sv
// Echo-width to centimetre converter: tick divider, saturating cm counter,
// half-cm flag for rounding and elapsed-time timeout compare.
module hcsr04_contador_cm
    import interface_hcsr04_multi_pkg::*;
#(
    parameter int LARGURA    = DEF_LARGURA,
    parameter int CICLOS_CM  = DEF_CICLOS_CM,
    parameter int TIMEOUT_CM = DEF_TIMEOUT_CM
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               zera,
    input  logic               conta,
    output logic [LARGURA-1:0] cm,
    output logic               meio,
    output logic               fim_timeout
);

    localparam int LIMITE = TIMEOUT_CM * CICLOS_CM;
    localparam int TW     = largura_contador(CICLOS_CM - 1);
    localparam int EW     = largura_contador(LIMITE);

    logic [TW-1:0]      tick_q, tick_d;
    logic [LARGURA-1:0] cm_q, cm_d;
    logic [EW-1:0]      decorrido_q, decorrido_d;

    // NOTE: every always_comb output gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        tick_d      = tick_q;
        cm_d        = cm_q;
        decorrido_d = decorrido_q;
        if (zera) begin
            tick_d      = '0;
            cm_d        = '0;
            decorrido_d = '0;
        end else begin
            // Elapsed time runs whether or not echo is high; it stops at the limit.
            if (decorrido_q != EW'(LIMITE)) decorrido_d = decorrido_q + EW'(1);
            if (conta) begin
                if (tick_q == TW'(CICLOS_CM - 1)) begin
                    tick_d = '0;
                    if (cm_q != '1) cm_d = cm_q + LARGURA'(1);
                end else begin
                    tick_d = tick_q + TW'(1);
                end
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            tick_q      <= '0;
            cm_q        <= '0;
            decorrido_q <= '0;
        end else begin
            tick_q      <= tick_d;
            cm_q        <= cm_d;
            decorrido_q <= decorrido_d;
        end
    end

    assign cm          = cm_q;
    assign meio        = (tick_q >= TW'(CICLOS_CM / 2));
    assign fim_timeout = (decorrido_q == EW'(LIMITE));

endmodule

// File: rtl/interface_hcsr04_multi.sv
// Round-robin HC-SR04 controller: triggers one sensor at a time, measures the
// synchronized echo width in cm and keeps the last result per channel.
module interface_hcsr04_multi
    import interface_hcsr04_multi_pkg::*;
#(
    parameter int N_CANAIS       = DEF_N_CANAIS,
    parameter int LARGURA        = DEF_LARGURA,
    parameter int CICLOS_TRIGGER = DEF_CICLOS_TRIGGER,
    parameter int CICLOS_CM      = DEF_CICLOS_CM,
    parameter int TIMEOUT_CM     = DEF_TIMEOUT_CM,
    parameter int CICLOS_PAUSA   = DEF_CICLOS_PAUSA
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          medir,
    input  logic                          continuo,
    input  logic [N_CANAIS-1:0]           echo,
    output logic [N_CANAIS-1:0]           trigger,
    output logic [N_CANAIS*LARGURA-1:0]   medida,
    output logic [N_CANAIS-1:0]           timeout,
    output logic                          pronto,
    output logic [2:0]                    canal,
    output logic [3:0]                    db_estado
);

    localparam int CW = largura_contador(
        (CICLOS_TRIGGER > CICLOS_PAUSA) ? CICLOS_TRIGGER : CICLOS_PAUSA);

    estado_t                        estado_q, estado_d;
    logic [2:0]                     canal_q, canal_d;
    logic [CW-1:0]                  cnt_q, cnt_d;
    logic                           tmo_q, tmo_d;
    logic [N_CANAIS-1:0]            trigger_q, trigger_d;
    logic [N_CANAIS*LARGURA-1:0]    medida_q, medida_d;
    logic [N_CANAIS-1:0]            timeout_q, timeout_d;
    logic                           pronto_q, pronto_d;

    logic [N_CANAIS-1:0]            echo_m_q, echo_s_q, echo_p_q;
    logic [N_CANAIS-1:0]            sel_atual, sel_prox;
    logic                           echo_sel, echo_ant, subida;
    logic                           zera, conta, meio, fim_timeout;
    logic [LARGURA-1:0]             cm, valor;

    // Two-flop synchronizer plus one delay stage for edge detection.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            echo_m_q <= '0;
            echo_s_q <= '0;
            echo_p_q <= '0;
        end else begin
            echo_m_q <= echo;
            echo_s_q <= echo_m_q;
            echo_p_q <= echo_s_q;
        end
    end

    assign sel_atual = N_CANAIS'(1) << canal_q;
    assign sel_prox  = N_CANAIS'(1) << canal_d;
    assign echo_sel  = |(echo_s_q & sel_atual);
    assign echo_ant  = |(echo_p_q & sel_atual);
    assign subida    = echo_sel & ~echo_ant;

    // The rising-edge cycle is counted too, so cm covers every high clock of echo.
    assign zera  = !(estado_q == ESPERA_ECHO || estado_q == MEDINDO);
    assign conta = (estado_q == ESPERA_ECHO && subida) || (estado_q == MEDINDO && echo_sel);
    assign valor = (meio && cm != '1) ? cm + LARGURA'(1) : cm;

    hcsr04_contador_cm #(
        .LARGURA    (LARGURA),
        .CICLOS_CM  (CICLOS_CM),
        .TIMEOUT_CM (TIMEOUT_CM)
    ) u_contador (
        .clock       (clock),
        .reset       (reset),
        .zera        (zera),
        .conta       (conta),
        .cm          (cm),
        .meio        (meio),
        .fim_timeout (fim_timeout)
    );

    always_comb begin
        estado_d  = estado_q;
        canal_d   = canal_q;
        cnt_d     = '0;
        tmo_d     = tmo_q;
        medida_d  = medida_q;
        timeout_d = timeout_q;
        case (estado_q)
            INICIAL: begin
                if (medir || continuo) begin
                    estado_d = PREPARA;
                    canal_d  = '0;
                end
            end
            PREPARA: begin
                estado_d = TRIGGER;
                tmo_d    = 1'b0;
            end
            TRIGGER: begin
                if (cnt_q == CW'(CICLOS_TRIGGER - 1)) estado_d = ESPERA_ECHO;
                else                                  cnt_d    = cnt_q + CW'(1);
            end
            ESPERA_ECHO: begin
                if (fim_timeout) begin
                    estado_d = REGISTRA;
                    tmo_d    = 1'b1;
                end else if (subida) begin
                    estado_d = MEDINDO;
                end
            end
            MEDINDO: begin
                if (fim_timeout) begin
                    estado_d = REGISTRA;
                    tmo_d    = 1'b1;
                end else if (!echo_sel) begin
                    estado_d = REGISTRA;
                end
            end
            REGISTRA: begin
                for (int k = 0; k < N_CANAIS; k++) begin
                    if (canal_q == 3'(k))
                        medida_d[k*LARGURA +: LARGURA] = tmo_q ? LARGURA'(TIMEOUT_CM) : valor;
                end
                timeout_d = (timeout_q & ~sel_atual) | (tmo_q ? sel_atual : '0);
                estado_d  = PAUSA;
            end
            PAUSA: begin
                if (cnt_q == CW'(CICLOS_PAUSA - 1)) begin
                    if (canal_q == 3'(N_CANAIS - 1)) begin
                        estado_d = FINAL;
                    end else begin
                        estado_d = PREPARA;
                        canal_d  = canal_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            FINAL: begin
                if (continuo) begin
                    estado_d = PREPARA;
                    canal_d  = '0;
                end else begin
                    estado_d = INICIAL;
                end
            end
            default: estado_d = INICIAL;
        endcase
    end

    // Pin outputs are registered from next-state so they are glitch-free and aligned with the state.
    assign trigger_d = (estado_d == TRIGGER) ? sel_prox : '0;
    assign pronto_d  = (estado_d == FINAL);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado_q  <= INICIAL;
            canal_q   <= '0;
            cnt_q     <= '0;
            tmo_q     <= 1'b0;
            trigger_q <= '0;
            medida_q  <= '0;
            timeout_q <= '0;
            pronto_q  <= 1'b0;
        end else begin
            estado_q  <= estado_d;
            canal_q   <= canal_d;
            cnt_q     <= cnt_d;
            tmo_q     <= tmo_d;
            trigger_q <= trigger_d;
            medida_q  <= medida_d;
            timeout_q <= timeout_d;
            pronto_q  <= pronto_d;
        end
    end

    assign trigger   = trigger_q;
    assign medida    = medida_q;
    assign timeout   = timeout_q;
    assign pronto    = pronto_q;
    assign canal     = canal_q;
    assign db_estado = estado_q;

endmodule

// File: tb/tb_interface_hcsr04_multi.sv
// Scoreboard bench for interface_hcsr04_multi: a sensor model answers each
// trigger with a programmed echo width and expected cm values are queued per scan.
module tb_interface_hcsr04_multi;

    localparam int N   = 3;
    localparam int L   = 12;
    localparam int CT  = 5;
    localparam int CCM = 10;
    localparam int TCM = 50;
    localparam int CP  = 20;

    logic           clock    = 1'b0;
    logic           reset    = 1'b0;
    logic           medir    = 1'b0;
    logic           continuo = 1'b0;
    logic [N-1:0]   echo     = '0;
    logic [N-1:0]   trigger;
    logic [N*L-1:0] medida;
    logic [N-1:0]   timeout;
    logic           pronto;
    logic [2:0]     canal;
    logic [3:0]     db_estado;

    interface_hcsr04_multi #(
        .N_CANAIS       (N),
        .LARGURA        (L),
        .CICLOS_TRIGGER (CT),
        .CICLOS_CM      (CCM),
        .TIMEOUT_CM     (TCM),
        .CICLOS_PAUSA   (CP)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .medir     (medir),
        .continuo  (continuo),
        .echo      (echo),
        .trigger   (trigger),
        .medida    (medida),
        .timeout   (timeout),
        .pronto    (pronto),
        .canal     (canal),
        .db_estado (db_estado)
    );

    always #5 clock = ~clock;

    typedef struct {
        int canal;
        int medida;
        bit tmo;
    } exp_t;

    exp_t sb[$];
    int n_checks   = 0;
    int n_pass     = 0;
    int cyc        = 0;
    int onehot_err = 0;
    int pronto_cnt = 0;
    int last_fall  = -1;
    int first_rise = -1;

    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        if (reset && !$onehot0(trigger)) onehot_err <= onehot_err + 1;
        if (pronto) pronto_cnt <= pronto_cnt + 1;
    end

    initial begin
        #900_000;
        $display("FAIL watchdog: got no end of run, expected finish before 900000 ns");
        $fatal(1);
    end

    function automatic logic [N-1:0] bit_de(input int k);
        return N'(1) << k;
    endfunction

    function automatic logic trig_em(input int k);
        return (trigger & bit_de(k)) != '0;
    endfunction

    // Echo width in clocks -> expected cm, round half up; negative width means no echo.
    function automatic int exp_cm(input int w);
        if (w < 0) return TCM;
        return w / CCM + (((w % CCM) >= CCM / 2) ? 1 : 0);
    endfunction

    task automatic push_scan(input int w0, input int w1, input int w2);
        int w[N];
        w[0] = w0; w[1] = w1; w[2] = w2;
        for (int k = 0; k < N; k++) begin
            exp_t e;
            e.canal  = k;
            e.medida = exp_cm(w[k]);
            e.tmo    = (w[k] < 0);
            sb.push_back(e);
        end
    endtask

    task automatic wait_trig(input int k, input logic val, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clock);
            ok = (trig_em(k) == val);
        end
    endtask

    task automatic sensor_scan(input int w0, input int w1, input int w2,
                               input bit glitch, input bit pre2, input bit drop_cont);
        int w[N];
        bit ok;
        int hi;
        w[0] = w0; w[1] = w1; w[2] = w2;
        for (int k = 0; k < N; k++) begin
            wait_trig(k, 1'b1, 3000, ok);
            if (!ok) begin
                n_checks++;
                $display("FAIL trigger%0d rise: got none, expected a rise within 3000 clocks", k);
                return;
            end
            if (k == 0) first_rise = cyc;
            if (last_fall >= 0) begin
                n_checks++;
                if (cyc - last_fall < CP)
                    $display("FAIL trigger gap ch%0d: got %0d clocks, expected >= %0d", k, cyc - last_fall, CP);
                else n_pass++;
            end
            if (pre2 && k == 2) echo = echo | bit_de(2);
            hi = 1;
            while (hi < 100) begin
                @(negedge clock);
                if (!trig_em(k)) break;
                hi++;
            end
            n_checks++;
            if (hi != CT) $display("FAIL trigger%0d width: got %0d clocks, expected %0d", k, hi, CT);
            else n_pass++;
            last_fall = cyc;
            if (drop_cont && k == 0) continuo = 1'b0;
            if (pre2 && k == 2) begin
                repeat (10) @(negedge clock);
                echo = echo & ~bit_de(2);
            end
            repeat (3) @(negedge clock);
            if (w[k] >= 0) begin
                echo = echo | bit_de(k);
                for (int i = 0; i < w[k]; i++) begin
                    @(negedge clock);
                    if (glitch && k == 0) begin
                        if (i == w[k] / 2) begin
                            echo  = echo | bit_de(2);
                            medir = 1'b1;
                        end
                        if (i == w[k] / 2 + 1) medir = 1'b0;
                        if (i == w[k] / 2 + 3) echo = echo & ~bit_de(2);
                    end
                end
                echo = echo & ~bit_de(k);
            end
        end
    endtask

    task automatic wait_pronto_compare(input string nome);
        bit ok;
        logic [L-1:0] mg;
        logic tg;
        ok = 1'b0;
        for (int i = 0; i < 3000 && !ok; i++) begin
            @(negedge clock);
            ok = (pronto === 1'b1);
        end
        n_checks++;
        if (!ok) begin
            $display("FAIL %s pronto: got none, expected a pulse within 3000 clocks", nome);
            return;
        end
        n_pass++;
        for (int k = 0; k < N; k++) begin
            exp_t e;
            if (sb.size() == 0) begin
                n_checks++;
                $display("FAIL %s scoreboard: got empty queue, expected %0d entries", nome, N - k);
                break;
            end
            e  = sb.pop_front();
            mg = L'(medida >> (e.canal * L));
            tg = |(timeout & bit_de(e.canal));
            n_checks++;
            if (mg !== L'(e.medida))
                $display("FAIL %s medida ch%0d: got %0d, expected %0d", nome, e.canal, mg, e.medida);
            else n_pass++;
            n_checks++;
            if (tg !== e.tmo)
                $display("FAIL %s timeout ch%0d: got %0b, expected %0b", nome, e.canal, tg, e.tmo);
            else n_pass++;
        end
        @(negedge clock);
        n_checks++;
        if (pronto !== 1'b0) $display("FAIL %s pronto width: got 1 on second clock, expected 0", nome);
        else n_pass++;
    endtask

    task automatic check_all_zero(input string nome);
        n_checks++;
        if (trigger !== '0 || medida !== '0 || timeout !== '0 || pronto !== 1'b0 ||
            canal !== 3'd0 || db_estado !== 4'd0)
            $display("FAIL %s outputs: got trig=%b medida=%h tmo=%b pronto=%b canal=%0d estado=%0d, expected all 0",
                     nome, trigger, medida, timeout, pronto, canal, db_estado);
        else n_pass++;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(negedge clock);
        check_all_zero("reset");
        reset = 1'b1;
        repeat (4) @(negedge clock);
        n_checks++;
        if (db_estado !== 4'd0 || trigger !== '0)
            $display("FAIL idle: got estado=%0d trig=%b, expected 0 and 000", db_estado, trigger);
        else n_pass++;
    endtask

    task automatic test_single_scan();
        int base, c0;
        base = pronto_cnt;
        push_scan(120, 255, 30);
        medir = 1'b1;
        c0 = cyc;
        @(negedge clock);
        medir = 1'b0;
        sensor_scan(120, 255, 30, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (first_rise - c0 != 2)
            $display("FAIL medir latency: got %0d clocks, expected 2", first_rise - c0);
        else n_pass++;
        wait_pronto_compare("single");
        repeat (3) @(negedge clock);
        n_checks++;
        if (pronto_cnt - base != 1 || db_estado !== 4'd0)
            $display("FAIL single end: got %0d pronto, estado %0d, expected 1 and 0", pronto_cnt - base, db_estado);
        else n_pass++;
    endtask

    task automatic test_timeout();
        push_scan(60, -1, 45);
        medir = 1'b1;
        @(negedge clock);
        medir = 1'b0;
        sensor_scan(60, -1, 45, 1'b0, 1'b0, 1'b0);
        wait_pronto_compare("timeout");
    endtask

    task automatic test_trigger();
        push_scan(14, 15, 10);
        medir = 1'b1;
        @(negedge clock);
        medir = 1'b0;
        sensor_scan(14, 15, 10, 1'b0, 1'b0, 1'b0);
        wait_pronto_compare("trigger");
        n_checks++;
        if (onehot_err != 0) $display("FAIL trigger one-hot: got %0d bad clocks, expected 0", onehot_err);
        else n_pass++;
    endtask

    task automatic test_continuous();
        int base;
        bit any_trig;
        base = pronto_cnt;
        continuo = 1'b1;
        push_scan(25, 44, 61);
        sensor_scan(25, 44, 61, 1'b0, 1'b0, 1'b0);
        wait_pronto_compare("cont1");
        push_scan(5, 9, 100);
        sensor_scan(5, 9, 100, 1'b0, 1'b0, 1'b0);
        wait_pronto_compare("cont2");
        push_scan(70, 71, 76);
        sensor_scan(70, 71, 76, 1'b0, 1'b0, 1'b1);
        wait_pronto_compare("cont3");
        repeat (2) @(negedge clock);
        n_checks++;
        if (db_estado !== 4'd0) $display("FAIL continuo stop: got estado %0d, expected 0", db_estado);
        else n_pass++;
        any_trig = 1'b0;
        repeat (60) begin
            @(negedge clock);
            if (trigger !== '0) any_trig = 1'b1;
        end
        n_checks++;
        if (any_trig || pronto_cnt - base != 3)
            $display("FAIL continuo count: got %0d pronto, extra trigger %0b, expected 3 and 0",
                     pronto_cnt - base, any_trig);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        bit ok;
        medir = 1'b1;
        @(negedge clock);
        medir = 1'b0;
        wait_trig(0, 1'b1, 100, ok);
        #1 reset = 1'b0;
        #1;
        n_checks++;
        if (!ok || trigger !== '0 || db_estado !== 4'd0)
            $display("FAIL async reset: got trig=%b estado=%0d seen=%0b, expected 000, 0, 1", trigger, db_estado, ok);
        else n_pass++;
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);

        medir = 1'b1;
        @(negedge clock);
        medir = 1'b0;
        wait_trig(0, 1'b1, 100, ok);
        wait_trig(0, 1'b0, 100, ok);
        repeat (3) @(negedge clock);
        echo = bit_de(0);
        repeat (40) @(negedge clock);
        echo = '0;
        wait_trig(1, 1'b1, 200, ok);
        wait_trig(1, 1'b0, 100, ok);
        repeat (3) @(negedge clock);
        echo = bit_de(1);
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clock);
            ok = (db_estado === 4'd4 && canal === 3'd1);
        end
        n_checks++;
        if (!ok) $display("FAIL reach medindo ch1: got estado %0d canal %0d, expected 4 and 1", db_estado, canal);
        else n_pass++;
        repeat (5) @(negedge clock);
        #1 reset = 1'b0;
        #1;
        check_all_zero("reset mid");
        echo = '0;
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        push_scan(22, 18, 16);
        medir = 1'b1;
        @(negedge clock);
        medir = 1'b0;
        sensor_scan(22, 18, 16, 1'b0, 1'b0, 1'b0);
        wait_pronto_compare("after reset");
    endtask

    task automatic test_glitch();
        int base;
        base = pronto_cnt;
        push_scan(40, 33, 27);
        medir = 1'b1;
        @(negedge clock);
        medir = 1'b0;
        sensor_scan(40, 33, 27, 1'b1, 1'b1, 1'b0);
        wait_pronto_compare("glitch");
        repeat (3) @(negedge clock);
        n_checks++;
        if (pronto_cnt - base != 1 || db_estado !== 4'd0)
            $display("FAIL glitch sequencing: got %0d pronto, estado %0d, expected 1 and 0", pronto_cnt - base, db_estado);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_single_scan();
        test_timeout();
        test_trigger();
        test_continuous();
        test_reset_mid();
        test_glitch();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
